// File: rtl/router_pkg.sv
// router_pkg: shared types and helpers for the ring output VC arbiter.
//   vc_state_t : one-hot VC scheduler states (IDLE/LOAD/FULL)
//   HOP_LSB    : LSB of the hop field inside a flit
//   HOP_WIDTH  : width of the shift-encoded hop field
//   hop_dec()  : consumes one hop (shift-encoded, so one hop is a right shift by 1)
package router_pkg;

    localparam int HOP_LSB   = 48;
    localparam int HOP_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LOAD = 3'b010,
        FULL = 3'b100
    } vc_state_t;

    function automatic logic [HOP_WIDTH-1:0] hop_dec(input logic [HOP_WIDTH-1:0] hop);
        return hop >> 1;
    endfunction

endpackage

// File: rtl/ring_out_vc_arbiter_vc_out_sched.sv
// vc_out_sched: one virtual channel of the ring output port.
//   clk, rst   : clock, asynchronous active-high reset
//   polarity   : link ownership; this VC may send only when polarity == MATCH_POL
//   ro         : downstream ready
//   req        : per-requester request, held until granted
//   data_in    : per-requester flits, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant      : one-hot, one-cycle pulse when the winner's flit is captured
//   send       : combinational, high in the cycle the buffered flit leaves
//   send_data  : buffered flit with its hop field already decremented
module vc_out_sched
    import router_pkg::*;
#(
    parameter int   DATA_WIDTH = 64,
    parameter int   NUM_REQ    = 3,
    parameter logic MATCH_POL  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          polarity,
    input  logic                          ro,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          send,
    output logic [DATA_WIDTH-1:0]         send_data
);

    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    vc_state_t             state, state_nxt;
    logic [IW-1:0]         ptr, winner, pick;
    logic [DATA_WIDTH-1:0] flit_q;
    logic                  load_ok;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) pick = IW'((int'(ptr) + k) % NUM_REQ);
    end

    assign send    = (state == FULL) && ro && (polarity == MATCH_POL);
    assign load_ok = (state == LOAD) && req[winner] && ro;

    always_comb begin
        send_data = flit_q;
        send_data[HOP_LSB +: HOP_WIDTH] = hop_dec(flit_q[HOP_LSB +: HOP_WIDTH]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req ? LOAD : IDLE;
            LOAD:    state_nxt = !req[winner] ? IDLE : ro ? FULL : LOAD;
            FULL:    state_nxt = send ? IDLE : FULL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            flit_q <= '0;
            grant  <= '0;
        end else begin
            state <= state_nxt;
            grant <= '0;
            if (state == IDLE && |req) winner <= pick;
            if (load_ok) begin
                flit_q <= data_in[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                grant  <= NUM_REQ'(1) << winner;
            end
            if (send) ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/ring_out_vc_arbiter.sv
// ring_out_vc_arbiter: shares one ring output link between an even and an odd VC scheduler.
//   clk, rst       : clock, asynchronous active-high reset
//   polarity       : 0 = even VC owns the link, 1 = odd VC owns the link
//   ro             : downstream ready
//   req_even/odd   : per-VC requests, one bit per requester
//   data_in_even/odd : per-VC flits, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant_even/odd : one-hot grant pulses (flit captured)
//   so             : one-cycle send valid per flit
//   data_out       : outgoing flit, hop field decremented; holds between sends
// Hop field position and width come from router_pkg.
module ring_out_vc_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          polarity,
    input  logic                          ro,
    input  logic [NUM_REQ-1:0]            req_even,
    input  logic [NUM_REQ-1:0]            req_odd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in_even,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in_odd,
    output logic [NUM_REQ-1:0]            grant_even,
    output logic [NUM_REQ-1:0]            grant_odd,
    output logic                          so,
    output logic [DATA_WIDTH-1:0]         data_out
);

    logic                  send_even, send_odd;
    logic [DATA_WIDTH-1:0] send_data_even, send_data_odd;

    vc_out_sched #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ), .MATCH_POL(1'b0)) u_even (
        .clk(clk), .rst(rst), .polarity(polarity), .ro(ro),
        .req(req_even), .data_in(data_in_even), .grant(grant_even),
        .send(send_even), .send_data(send_data_even)
    );

    vc_out_sched #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ), .MATCH_POL(1'b1)) u_odd (
        .clk(clk), .rst(rst), .polarity(polarity), .ro(ro),
        .req(req_odd), .data_in(data_in_odd), .grant(grant_odd),
        .send(send_odd), .send_data(send_data_odd)
    );

    // Polarity makes send_even and send_odd mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            so       <= 1'b0;
            data_out <= '0;
        end else begin
            so       <= send_even | send_odd;
            data_out <= send_even ? send_data_even : send_odd ? send_data_odd : data_out;
        end
    end

endmodule

// File: tb/tb_ring_out_vc_arbiter.sv
// tb_ring_out_vc_arbiter: directed self-checking bench for ring_out_vc_arbiter.
module tb_ring_out_vc_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         polarity;
    logic         ro;
    logic [2:0]   req_even, req_odd;
    logic [191:0] data_in_even, data_in_odd;
    logic [2:0]   grant_even, grant_odd;
    logic         so;
    logic [63:0]  data_out;

    int tests = 0;
    int fails = 0;

    ring_out_vc_arbiter #(.DATA_WIDTH(64), .NUM_REQ(3)) dut (
        .clk(clk), .rst(rst), .polarity(polarity), .ro(ro),
        .req_even(req_even), .req_odd(req_odd),
        .data_in_even(data_in_even), .data_in_odd(data_in_odd),
        .grant_even(grant_even), .grant_odd(grant_odd),
        .so(so), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; requesters drop a request while its grant is visible.
    task automatic step();
        @(negedge clk);
        req_even = req_even & ~grant_even;
        req_odd  = req_odd & ~grant_odd;
    endtask

    initial begin
        rst = 1'b1; polarity = 1'b0; ro = 1'b0;
        req_even = '0; req_odd = '0; data_in_even = '0; data_in_odd = '0;
        #1;
        chk("rst_grant_even", 64'(grant_even), 64'h0);
        chk("rst_grant_odd", 64'(grant_odd), 64'h0);
        chk("rst_so", 64'(so), 64'h0);
        chk("rst_data_out", data_out, 64'h0);
        step(); step();
        rst = 1'b0;

        // Single even request: grant after two edges, send after three, hop 0x04 -> 0x02
        data_in_even[0 +: 64] = 64'h0004_0000_0000_00AA;
        req_even = 3'b001; ro = 1'b1; polarity = 1'b0;
        step(); chk("t1_load_no_grant", 64'(grant_even), 64'h0);
        step(); chk("t1_grant", 64'(grant_even), 64'h1);
        chk("t1_no_so_yet", 64'(so), 64'h0);
        step(); chk("t1_so", 64'(so), 64'h1);
        chk("t1_hop_dec", data_out, 64'h0002_0000_0000_00AA);

        // Asynchronous reset between edges clears outputs immediately
        #2 rst = 1'b1;
        #1;
        chk("async_rst_so", 64'(so), 64'h0);
        chk("async_rst_data_out", data_out, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Round robin over three held requests, pointer starting at 0
        data_in_even[0 +: 64]   = 64'h1180_0000_0000_0001;
        data_in_even[64 +: 64]  = 64'h22FF_0000_0000_0002;
        data_in_even[128 +: 64] = 64'hFF00_FFFF_FFFF_FFFF;
        req_even = 3'b111;
        step(); chk("rr0_load", 64'(grant_even), 64'h0);
        step(); chk("rr0_grant", 64'(grant_even), 64'h1);
        step(); chk("rr0_so", 64'(so), 64'h1);
        chk("rr0_data", data_out, 64'h1140_0000_0000_0001);
        step(); chk("rr1_idle_so", 64'(so), 64'h0);
        step(); chk("rr1_grant", 64'(grant_even), 64'h2);
        step(); chk("rr1_so", 64'(so), 64'h1);
        chk("rr1_data", data_out, 64'h227F_0000_0000_0002);
        step(); chk("rr2_idle_so", 64'(so), 64'h0);
        step(); chk("rr2_grant", 64'(grant_even), 64'h4);
        step(); chk("rr2_so", 64'(so), 64'h1);
        chk("rr2_hop_zero", data_out, 64'hFF00_FFFF_FFFF_FFFF);
        step(); chk("rr_done_so", 64'(so), 64'h0);
        chk("rr_data_hold", data_out, 64'hFF00_FFFF_FFFF_FFFF);

        // Polarity gating: odd flit buffered while even owns the link
        data_in_odd[0 +: 64] = 64'h3301_0000_0000_0033;
        req_odd = 3'b001; polarity = 1'b0;
        step(); step(); chk("pol_grant_odd", 64'(grant_odd), 64'h1);
        chk("pol_no_even_grant", 64'(grant_even), 64'h0);
        step(); chk("pol_blocked0", 64'(so), 64'h0);
        step(); chk("pol_blocked1", 64'(so), 64'h0);
        polarity = 1'b1;
        step(); chk("pol_so", 64'(so), 64'h1);
        chk("pol_data", data_out, 64'h3300_0000_0000_0033);
        polarity = 1'b0;

        // Backpressure in LOAD and in FULL; captured flit survives input changes
        data_in_even[64 +: 64] = 64'h4410_5555_0000_0044;
        req_even = 3'b010; ro = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step(); chk("bp_load_no_grant", 64'(grant_even), 64'h0);
        end
        ro = 1'b1;
        step(); chk("bp_grant", 64'(grant_even), 64'h2);
        ro = 1'b0;
        data_in_even[64 +: 64] = 64'hDEAD_BEEF_DEAD_BEEF;
        step(); chk("bp_full_blocked0", 64'(so), 64'h0);
        step(); chk("bp_full_blocked1", 64'(so), 64'h0);
        ro = 1'b1;
        step(); chk("bp_so", 64'(so), 64'h1);
        chk("bp_data", data_out, 64'h4408_5555_0000_0044);

        // Concurrency: both VCs hold a flit; odd pointer sits at 1 after its earlier send
        data_in_even[0 +: 64]  = 64'h5520_0000_0000_0055;
        data_in_odd[0 +: 64]   = 64'h77C0_0000_0000_0077;
        data_in_odd[64 +: 64]  = 64'h6602_0000_0000_0066;
        req_even = 3'b001; req_odd = 3'b011; ro = 1'b1; polarity = 1'b0;
        step();
        step(); chk("cc_grant_even", 64'(grant_even), 64'h1);
        chk("cc_grant_odd", 64'(grant_odd), 64'h2);
        ro = 1'b0;
        step(); chk("cc_hold", 64'(so), 64'h0);
        ro = 1'b1;
        step(); chk("cc_even_so", 64'(so), 64'h1);
        chk("cc_even_data", data_out, 64'h5510_0000_0000_0055);
        polarity = 1'b1;
        step(); chk("cc_odd_so", 64'(so), 64'h1);
        chk("cc_odd_data", data_out, 64'h6601_0000_0000_0066);
        step(); chk("cc_odd_idle", 64'(so), 64'h0);
        step(); chk("cc_odd_wrap_grant", 64'(grant_odd), 64'h1);
        polarity = 1'b0;
        step(); chk("cc_odd_gated", 64'(so), 64'h0);
        polarity = 1'b1;
        step(); chk("cc_odd2_so", 64'(so), 64'h1);
        chk("cc_odd2_data", data_out, 64'h7760_0000_0000_0077);
        step(); chk("cc_final_idle", 64'(so), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
